// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Decode-stage interlock for an in-order pipeline. For every source operand it
// selects the bypass path, raises a data hazard when a value is not ready yet,
// raises a structural hazard when the single multi-cycle unit is busy, detects
// branch mispredicts and holds the front-end flush for a programmable number of
// cycles. A saturating counter records the number of stall cycles.

module hazard_scoreboard #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int FLUSH_CYCLES   = 1,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 2)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  srcValid,
  input  logic [NUM_SRC-1:0][4:0]             srcAddr,
  input  logic [NUM_FWD_STAGES-1:0]           stageWEnable,
  input  logic [NUM_FWD_STAGES-1:0][4:0]      stageRdAddr,
  input  logic [NUM_FWD_STAGES-1:0]           stageForwardable,
  input  logic                                issueValid,
  input  logic                                issueWEnable,
  input  logic [4:0]                          issueRdAddr,
  input  logic                                issueIsLong,
  input  logic                                longDone,
  input  logic [4:0]                          longDoneRdAddr,
  input  logic                                branchResolveValid,
  input  logic                                branchTaken,
  input  logic                                branchPredicted,
  output logic [NUM_SRC-1:0][SEL_W-1:0]       bypassSel,
  output logic                                isDataHazard,
  output logic                                isStructHazard,
  output logic                                isBranchPredictMiss,
  output logic                                flush,
  output logic [31:0]                         hazardStallCount
);

  // Select code for the value written back by the multi-cycle unit.
  localparam logic [SEL_W-1:0] SEL_LONG   = SEL_W'(NUM_FWD_STAGES + 1);
  // The mispredict cycle itself is the first flush cycle, so the counter
  // only has to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // Registered state.
  logic [31:0] r_pending;
  logic        r_long_busy;
  logic [3:0]  r_flush_cnt;
  logic [31:0] r_stall_cnt;

  // Combinational results.
  logic [NUM_SRC-1:0][SEL_W-1:0] w_sel;
  logic [NUM_SRC-1:0]            w_src_hazard;
  logic                          w_mispredict;
  logic                          w_flush;
  logic                          w_data_hazard;
  logic                          w_struct_hazard;
  logic                          w_issue_accept;
  logic                          w_stall;
  logic [31:0]                   w_pending_set;
  logic [31:0]                   w_pending_clr;
  logic [31:0]                   w_pending_next;
  logic                          w_long_busy_next;
  logic [3:0]                    w_flush_cnt_next;

  // Per-operand bypass selection and readiness, youngest producer first.
  always_comb begin : p_resolve
    logic v_matched;
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    w_sel        = '0;
    w_src_hazard = '0;
    v_matched    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      v_matched = 1'b0;
      if (srcValid[i] && (srcAddr[i] != 5'd0)) begin
        // The youngest matching stage owns the value; older writers of the
        // same register are stale and must be ignored.
        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
          if (!v_matched && stageWEnable[k] && (stageRdAddr[k] == srcAddr[i])) begin
            v_matched = 1'b1;
            if (stageForwardable[k]) begin
              w_sel[i] = SEL_W'(k + 1);
            end else begin
              w_src_hazard[i] = 1'b1;
            end
          end
        end
        if (!v_matched) begin
          if (longDone && (longDoneRdAddr == srcAddr[i])) begin
            w_sel[i] = SEL_LONG;
          end else if (r_pending[srcAddr[i]]) begin
            w_src_hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  // Mispredict detection, flush and stall qualification.
  always_comb begin
    w_mispredict    = branchResolveValid & (branchTaken ^ branchPredicted);
    w_flush         = w_mispredict | (r_flush_cnt != 4'd0);
    // Instructions in decode are squashed during a flush, so stalling them
    // would only waste cycles.
    w_data_hazard   = (|w_src_hazard) & ~w_flush;
    w_struct_hazard = issueValid & issueIsLong & r_long_busy & ~longDone & ~w_flush;
    w_issue_accept  = issueValid & ~w_data_hazard & ~w_struct_hazard & ~w_flush;
    w_stall         = w_data_hazard | w_struct_hazard;
  end

  // Next pending vector: writeback clears, accepted long issue sets, set wins.
  always_comb begin
    w_pending_set = '0;
    w_pending_clr = '0;
    if (w_issue_accept && issueIsLong && issueWEnable && (issueRdAddr != 5'd0)) begin
      w_pending_set[issueRdAddr] = 1'b1;
    end
    if (longDone) begin
      w_pending_clr[longDoneRdAddr] = 1'b1;
    end
    // x0 is hardwired to zero and can never be outstanding.
    w_pending_next = ((r_pending & ~w_pending_clr) | w_pending_set) & ~32'd1;
  end

  // Next long-unit occupancy: a new issue in the writeback cycle keeps it busy.
  always_comb begin
    w_long_busy_next = r_long_busy;
    if (longDone) begin
      w_long_busy_next = 1'b0;
    end
    if (w_issue_accept && issueIsLong) begin
      w_long_busy_next = 1'b1;
    end
  end

  // Next flush count: a mispredict (re)loads, otherwise count down to zero.
  always_comb begin
    w_flush_cnt_next = r_flush_cnt;
    if (w_mispredict) begin
      w_flush_cnt_next = FLUSH_LOAD;
    end else if (r_flush_cnt != 4'd0) begin
      w_flush_cnt_next = r_flush_cnt - 4'd1;
    end
  end

  // Scoreboard state registers; a flush leaves pending and busy untouched so
  // in-flight long ops retire normally.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all state is a handful of flops, so every register is reset
    // asynchronously; that drops a flush or long op without waiting for clk.
    if (!rst) begin
      r_pending   <= '0;
      r_long_busy <= 1'b0;
      r_flush_cnt <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_pending   <= w_pending_next;
      r_long_busy <= w_long_busy_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // Saturating count of decode stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bypassSel           = w_sel;
  assign isDataHazard        = w_data_hazard;
  assign isStructHazard      = w_struct_hazard;
  assign isBranchPredictMiss = w_mispredict;
  assign flush               = w_flush;
  assign hazardStallCount    = r_stall_cnt;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2: number of source operands checked per decoded instruction.
REQ-002 The block SHALL have parameter NUM_FWD_STAGES, default 2: forwarding stages; index 0 is youngest (execute), index 1 is memory access.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 1, range 1-15: cycles the flush is held after a mispredict.
REQ-004 The block SHALL have parameter SEL_W = clog2(NUM_FWD_STAGES+2): bypass select width.
REQ-005 The block SHALL run on one clock and an asynchronous, active-low reset.
REQ-006 The block SHALL have these ports, one per line:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active low.
- srcValid  in  NUM_SRC  operand i is read from the register file.
- srcAddr  in  NUM_SRC x 5  register address of operand i.
- stageWEnable  in  NUM_FWD_STAGES  stage k writes rd.
- stageRdAddr  in  NUM_FWD_STAGES x 5  rd of stage k.
- stageForwardable  in  NUM_FWD_STAGES  stage k's result is available for bypass.
- issueValid  in  1  decode offers an instruction.
- issueWEnable  in  1  the offered instruction writes rd.
- issueRdAddr  in  5  rd of the offered instruction.
- issueIsLong  in  1  the offered instruction goes to the multi-cycle unit.
- longDone  in  1  the multi-cycle unit writes back this cycle.
- longDoneRdAddr  in  5  rd of that writeback.
- branchResolveValid  in  1  a branch resolves this cycle.
- branchTaken  in  1  actual branch direction.
- branchPredicted  in  1  predicted branch direction.
- bypassSel  out  NUM_SRC x SEL_W  0 = register file, k+1 = stage k, NUM_FWD_STAGES+1 = longDone result.
- isDataHazard  out  1  stall decode, operand not ready.
- isStructHazard  out  1  stall decode, long unit busy.
- isBranchPredictMiss  out  1  mispredict this cycle.
- flush  out  1  squash the front-end stages.
- hazardStallCount  out  32  saturating count of stall cycles.

Function
REQ-007 Per operand i, the block SHALL resolve in priority order:
- srcValid=0 or srcAddr=0: sel 0, no hazard.
- Lowest k with stageWEnable[k] and stageRdAddr[k]==srcAddr: sel k+1 if stageForwardable[k], else hazard with sel 0; older stages are ignored.
- longDone and longDoneRdAddr==srcAddr: sel NUM_FWD_STAGES+1.
- pending[srcAddr]=1: hazard.
- Otherwise: sel 0.
REQ-008 isDataHazard SHALL be the OR of the per-operand hazards; it is combinational (zero latency).
REQ-009 isStructHazard SHALL equal issueValid & issueIsLong & longBusy & ~longDone.
REQ-010 Accepted issue SHALL be defined as issueValid & ~isDataHazard & ~isStructHazard & ~flush.
REQ-011 The pending register (32 bits, bit 0 always 0) SHALL be updated as follows:
- Set bit issueRdAddr on an accepted issue with issueIsLong & issueWEnable & issueRdAddr≠0.
- Clear bit longDoneRdAddr on longDone.
- If set and clear hit the same bit in the same cycle, set SHALL win.
REQ-012 longBusy SHALL be set on an accepted issue with issueIsLong and cleared on longDone; if both occur in one cycle it SHALL end at 1.
REQ-013 isBranchPredictMiss SHALL equal branchResolveValid & (branchTaken ≠ branchPredicted), combinationally.
REQ-014 flush SHALL follow these rules:
- It asserts combinationally in the mispredict cycle and stays high for FLUSH_CYCLES cycles in total, using a 4-bit down-counter.
- A new mispredict during a flush SHALL restart the count.
- While flush=1, isDataHazard and isStructHazard SHALL be forced to 0.
REQ-015 A flush SHALL NOT clear pending or longBusy; an in-flight long op completes and clears its own state via longDone.
REQ-016 hazardStallCount SHALL increment each cycle that isDataHazard|isStructHazard, saturating at 0xFFFFFFFF.

Reset
REQ-017 While rst=0, the block SHALL hold pending=0, longBusy=0, the flush counter at 0, flush=0 and hazardStallCount=0; the combinational outputs then follow their inputs.
REQ-018 Reset asserted mid-flush or mid-long-op SHALL drop all registered state immediately, without waiting for a clock.

Verification
REQ-019 Bench scenario, bypass priority: stage0 and stage1 both write x5, both forwardable, srcAddr[0]=5 -> bypassSel[0]=1, isDataHazard=0.
REQ-020 Bench scenario, load-use: stage0 writes x7 with forwardable=0, srcAddr[1]=7 -> isDataHazard=1; next cycle stage1 holds x7 forwardable -> bypassSel[1]=2.
REQ-021 Bench scenario, long op: accepted long issue to x9, then a read of x9 -> hazard for 3 cycles; longDone on x9 -> bypassSel=3 that cycle, pending[9]=0 after; hazardStallCount=3.
REQ-022 Bench scenario, structural: second long issue while longBusy -> isStructHazard=1; the same op in a longDone cycle -> accepted, longBusy stays 1.
REQ-023 Bench scenario, flush: FLUSH_CYCLES=3, mispredict at cycle 0 -> flush high for cycles 0-2; a second mispredict at cycle 1 -> flush high through cycle 3.
REQ-024 Bench scenario, reset: rst low mid-flush with pending[4]=1 -> flush=0, pending=0, hazardStallCount=0 asynchronously.
